// File: rtl/fifo_pkg.sv
// FIFO shared defaults: word width, depth, threshold
// and the derived pointer width.
package fifo_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int THRESH = 12;
  localparam int ADDR_W = $clog2(DEPTH);
endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_W register file.
// Ports: clk, i_we/i_waddr/i_wdata sync write, i_raddr -> o_rdata async read.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  // contents are never reset
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo.sv
// Synchronous circular-buffer FIFO with full/empty/threshold decodes
// and registered overflow/underflow. Ports: clk, rst(n), wr/wr_in, rd/rd_out, flags.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int DEPTH  = fifo_pkg::DEPTH,
  parameter int THRESH = fifo_pkg::THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_in,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_out,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  output logic              threshold
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_THR  = (AW+1)'(THRESH);

  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_cnt;
  logic [DATA_W-1:0] r_rd_out;
  logic              r_ovf;
  logic              r_unf;
  logic [DATA_W-1:0] w_rdata;
  logic              w_wr_ok;
  logic              w_rd_ok;

  assign full      = (r_cnt == LP_FULL);
  assign empty     = (r_cnt == '0);
  assign threshold = (r_cnt >= LP_THR);

  // a read frees a slot in the same edge, so full+rd still writes
  assign w_wr_ok = wr & (~full | rd);
  assign w_rd_ok = rd & ~empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_wptr),
    .i_wdata (wr_in),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_rd_out <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_ok)
        r_wptr <= r_wptr + AW'(1);
      if (w_rd_ok) begin
        r_rptr   <= r_rptr + AW'(1);
        r_rd_out <= w_rdata;
      end
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_ovf <= wr & full & ~rd;
      r_unf <= rd & empty;
    end
  end

  assign rd_out    = r_rd_out;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo with a queue scoreboard
// and per-cycle flag checks.
module tb_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] wr_in;
  logic       rd;
  logic [7:0] rd_out;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;
  logic       threshold;

  int total = 0;
  int bad   = 0;
  int stepn = 0;

  logic [7:0] mq[$];
  logic [7:0] last_rd;
  logic [7:0] words [16] = '{
    8'hf4, 8'ha4, 8'h9d, 8'ha3, 8'h82, 8'he4, 8'ha8, 8'h93,
    8'hc3, 8'ha2, 8'h63, 8'ha5, 8'hc3, 8'hb2, 8'hb2, 8'hc3};

  fifo dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr),
    .wr_in     (wr_in),
    .rd        (rd),
    .rd_out    (rd_out),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow),
    .threshold (threshold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%h expected=%h",
             tag, stepn, obs, exp);
    end
  endtask

  task automatic chk_flags(input int n);
    chk("empty",     {7'd0, empty},     {7'd0, n == 0});
    chk("full",      {7'd0, full},      {7'd0, n == 16});
    chk("threshold", {7'd0, threshold}, {7'd0, n >= 12});
  endtask

  // one clock of stimulus; expectations come from the queue model
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    bit mfull, mempty, rd_ok, wr_ok, eov, eun;
    logic [7:0] erd;
    mfull  = (mq.size() == 16);
    mempty = (mq.size() == 0);
    rd_ok  = r && !mempty;
    wr_ok  = w && (!mfull || r);
    eov    = w && mfull && !r;
    eun    = r && mempty;
    erd    = last_rd;
    if (rd_ok) erd = mq.pop_front();
    if (wr_ok) mq.push_back(d);
    wr = w; wr_in = d; rd = r;
    @(posedge clk);
    #1;
    stepn++;
    chk("rd_out",    rd_out,              erd);
    chk("overflow",  {7'd0, overflow},    {7'd0, eov});
    chk("underflow", {7'd0, underflow},   {7'd0, eun});
    chk_flags(mq.size());
    last_rd = erd;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic reset_checks();
    chk("rst_rd_out", rd_out,             8'h00);
    chk("rst_ovf",    {7'd0, overflow},   8'h00);
    chk("rst_unf",    {7'd0, underflow},  8'h00);
    chk_flags(0);
  endtask

  initial begin
    rst = 1'b0; wr = 1'b0; rd = 1'b0; wr_in = 8'h00;
    last_rd = 8'h00;
    #1;
    reset_checks();
    #11 rst = 1'b1;

    // fill 16, flags tracked every cycle
    for (int i = 0; i < 16; i++) cyc(1'b1, words[i], 1'b0);
    // write while full is dropped
    cyc(1'b1, 8'h9d, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    // drain in order
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("drain_last", rd_out, 8'hc3);
    // read on empty underflows, rd_out holds
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    // rd+wr while empty: only the write is taken
    cyc(1'b1, 8'h77, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("empty_rdwr_data", rd_out, 8'h77);

    // fill, then simultaneous rd/wr at full, then drain across wrap
    for (int i = 0; i < 16; i++) cyc(1'b1, words[i], 1'b0);
    cyc(1'b1, 8'h55, 1'b1);
    chk("full_rdwr_data", rd_out, 8'hf4);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("wrap_last", rd_out, 8'h55);

    // async reset in the middle of a clock period
    for (int i = 0; i < 5; i++) cyc(1'b1, words[i], 1'b0);
    #3 rst = 1'b0;
    #1;
    reset_checks();
    mq.delete();
    last_rd = 8'h00;
    #2 rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of storage entries (power of two).
REQ-003 Parameter THRESH, default 12, occupancy level at which threshold asserts.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wr  input  1  write request, sampled on rising clk.
REQ-007 wr_in  input  DATA_W  write data, captured when a write is accepted.
REQ-008 rd  input  1  read request, sampled on rising clk.
REQ-009 rd_out  output  DATA_W  registered read data.
REQ-010 full  output  1  occupancy == DEPTH.
REQ-011 empty  output  1  occupancy == 0.
REQ-012 overflow  output  1  registered flag: the previous cycle's write was rejected.
REQ-013 underflow  output  1  registered flag: the previous cycle's read was rejected.
REQ-014 threshold  output  1  occupancy >= THRESH.
REQ-015 Port order SHALL be clk, rst, wr, wr_in, rd, rd_out, full, empty, overflow, underflow, threshold.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH x DATA_W, with a write pointer, a read pointer (each log2(DEPTH) bits, wrapping DEPTH-1 -> 0), and an occupancy count of log2(DEPTH)+1 bits.
REQ-017 A write SHALL be accepted when wr=1 and (full=0 or rd=1): mem[wptr] <= wr_in, wptr increments.
REQ-018 A read SHALL be accepted when rd=1 and empty=0: rd_out <= mem[rptr] at that edge (1-cycle latency), rptr increments.
REQ-019 When no read is accepted, rd_out SHALL hold its last value.
REQ-020 Occupancy SHALL increment on an accepted write only, decrement on an accepted read only, and stay unchanged when both are accepted.
REQ-021 Simultaneous rd and wr while full SHALL perform both operations; occupancy stays DEPTH and overflow stays 0.
REQ-022 Simultaneous rd and wr while empty SHALL accept only the write; underflow asserts.
REQ-023 full, empty and threshold SHALL be combinational decodes of the registered occupancy.
REQ-024 overflow SHALL be registered to 1 for exactly the cycle following an edge where wr=1, full=1 and rd=0, and 0 otherwise; the data is dropped.
REQ-025 underflow SHALL be registered to 1 for exactly the cycle following an edge where rd=1 and empty=1, and 0 otherwise; rd_out is unchanged.
REQ-026 Data SHALL emerge in strict write order across pointer wrap-around.

Reset
REQ-027 rst=0 SHALL immediately clear both pointers, the count, rd_out, overflow and underflow to 0, giving empty=1, full=0 and threshold=0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset mid-operation SHALL discard all stored entries.
REQ-030 The first edge after rst rises SHALL be a normal operating edge.

Structure
REQ-031 Package fifo_pkg SHALL hold DATA_W, DEPTH, THRESH defaults and the derived ADDR_W = log2(DEPTH).
REQ-032 The storage array SHALL be one sub-module, fifo_mem: a synchronous-write, asynchronous-read register file. Pointers, count and flags remain in fifo.

Verification
REQ-033 Reset, then write 16 words (f4,a4,9d,a3,82,e4,a8,93,c3,a2,63,a5,c3,b2,b2,c3) on consecutive cycles, rd=0 -> empty falls after word 1, threshold rises after word 12, full=1 after word 16, overflow=0.
REQ-034 With the FIFO full, write 9d with rd=0 -> overflow=1 for one cycle, count stays 16, 9d is never read out.
REQ-035 Then hold rd=1 for 16 cycles -> rd_out = f4,a4,...,c3 in order, each one cycle after its rd edge; threshold falls when count drops to 11; empty=1 after the last read.
REQ-036 rd=1 on an empty FIFO -> underflow=1 for one cycle, rd_out keeps c3.
REQ-037 Fill to 16, then rd=1 and wr=1 with 55 -> rd_out=f4, full stays 1, no overflow; after 16 further reads, 55 emerges last (wrap-around).
REQ-038 Pull rst low asynchronously mid-clock with count 5 -> outputs clear without waiting for a clock edge; the next read underflows.
